alu_rx_interface: RTL and testbench
===================================

Name: alu_rx_interface

Overview:
Sequencer between a byte-oriented serial receiver/transmitter pair and the combinational ALU (ALU ports: dato1, dato2, op_code in; salida out).
- Collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs.
- Captures salida one cycle later and hands the result byte to the transmitter through a start/busy handshake.
- It is the writer side of the ALU operand interface, replacing switch/testbench stimulus in the serial top level.

Parameters:
NB_DATA, 8, width of rx/tx byte bus
NB_IN, 8, ALU operand width (NB_IN <= NB_DATA)
NB_OUT, 8, ALU result width (NB_OUT <= NB_DATA)
NB_CODE, 6, ALU opcode width (NB_CODE <= NB_DATA)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
rx_data  in  NB_DATA  received byte, valid when rx_done=1
rx_done  in  1  one-cycle strobe, new byte available
dato1  out  NB_IN  operand A to ALU
dato2  out  NB_IN  operand B to ALU
op_code  out  NB_CODE  opcode to ALU
salida  in  NB_OUT  ALU result (combinational from dato1/dato2/op_code)
tx_data  out  NB_DATA  result byte to transmitter
tx_start  out  1  one-cycle pulse, transmitter loads tx_data
tx_busy  in  1  transmitter busy; no tx_start while high
ready  out  1  high while waiting for an input byte
error  out  1  opcode-check flag (see Optional Feature)

Behaviour:
- One clock, clk. Reset is synchronous and active-high: reset sampled high at a rising edge of clk forces the reset state at that edge.
- Reset state, regardless of current state:
  - state=WAIT_A; dato1=0, dato2=0, op_code=0, tx_data=0, tx_start=0, error=0.
  - ready=1 from the first cycle after the reset edge.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A: on rx_done, dato1<=rx_data[NB_IN-1:0], go WAIT_B.
- WAIT_B: on rx_done, dato2<=rx_data[NB_IN-1:0], go WAIT_OP.
- WAIT_OP: on rx_done, op_code<=rx_data[NB_CODE-1:0], go EXEC.
- EXEC (exactly 1 cycle, lets the ALU settle): tx_data<=zero-extended salida, go SEND.
- SEND:
  - tx_busy=0: tx_start<=1 for exactly one cycle, go WAIT_A.
  - tx_busy=1: hold; tx_data stable.
- Latency: with the opcode rx_done sampled at edge k, tx_data is valid after edge k+1 and tx_start is high during cycle k+2..k+3, provided tx_busy=0.
- ready = state in {WAIT_A, WAIT_B, WAIT_OP} (decoded from state register, no extra latency).
- rx_done while in EXEC or SEND: byte discarded, no state change. The next packet must start after ready=1.
- dato1/dato2/op_code hold their values between packets; they change only at their own capture edge.
- No timeout: a partial packet waits indefinitely; only reset aborts it.
- Reset asserted in SEND with tx_busy=0: reset wins, no tx_start.

Optional Feature:
Macro ALU_IF_OPCHECK_EN.
- Defined:
  - In WAIT_OP, the received opcode is compared against the legal set: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Illegal opcode: op_code is not updated. The FSM goes EXEC→SEND with tx_data<=all ones and error<=1.
  - error clears at the next WAIT_A rx_done.
- Undefined:
  - Any opcode is passed to the ALU unchanged; tx_data=salida.
  - error is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams ADD, SUB, AND, OR, XOR, SRA, SRL, NOR (NB_CODE=6 encodings above);
  - the FSM state encoding (3 bits);
  - the error byte constant.
- ALU and bench import the same package.
- No sub-module: the FSM and capture registers stay in one module. An opcode-legality function lives in alu_pkg.

Test Plan:
1. Reset, then bytes 0x05, 0x03, 0x20 with tx_busy=0 → dato1=0x05, dato2=0x03, op_code=0x20; tx_data=0x08; single tx_start pulse 2 cycles after the opcode strobe; ready returns to 1.
2. Bytes 0x03, 0x05, 0x22 (SUB) → tx_data=0xFE. Bytes 0x80, 0x02, 0x03 (SRA) → tx_data=0xE0. Bytes 0x80, 0x02, 0x02 (SRL) → tx_data=0x20.
3. tx_busy held high 10 cycles during SEND; inject rx_done=0x55 there → tx_start only after tx_busy falls. The 0x55 is ignored, and the next packet 0x0F, 0xF0, 0x27 (NOR) → tx_data=0x00.
4. Reset after operand A only, then full packet 0xAA, 0x0F, 0x24 (AND) → tx_data=0x0A. No tx_start from the aborted packet; outputs zero right after reset.
5. With ALU_IF_OPCHECK_EN: bytes 0x01, 0x01, 0x3F → op_code keeps its previous value, tx_data=0xFF, error=1. A following legal ADD packet 0x01, 0x01, 0x20 → error=0, tx_data=0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, sequencer state encoding and error byte
// Optional opcode checking in alu_rx_interface is enabled by ALU_IF_OPCHECK_EN.
package alu_pkg;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] XOR = 6'b100110;
   localparam logic [5:0] SRA = 6'b000011;
   localparam logic [5:0] SRL = 6'b000010;
   localparam logic [5:0] NOR = 6'b100111;

   localparam logic [7:0] ERR_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4
   } state_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         ADD, SUB, AND, OR, XOR, SRA, SRL, NOR: is_legal_op = 1'b1;
         default:                               is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_rx_interface.sv
// rtl/alu_rx_interface.sv - collects A, B, opcode bytes for the ALU and sends the result byte
// Define ALU_IF_OPCHECK_EN to reject illegal opcodes with an error byte and error flag.
module alu_rx_interface
   import alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_IN   = 8,
   parameter int NB_OUT  = 8,
   parameter int NB_CODE = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic               rx_done,
   output logic [NB_IN-1:0]   dato1,
   output logic [NB_IN-1:0]   dato2,
   output logic [NB_CODE-1:0] op_code,
   input  logic [NB_OUT-1:0]  salida,
   output logic [NB_DATA-1:0] tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               ready,
   output logic               error
);

   state_t state, state_next;

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_A;
      else       state <= state_next;
   end

   // Bytes arriving in EXEC or SEND are dropped simply by not advancing.
   always_comb begin
      state_next = state;
      case (state)
         WAIT_A:  if (rx_done)  state_next = WAIT_B;
         WAIT_B:  if (rx_done)  state_next = WAIT_OP;
         WAIT_OP: if (rx_done)  state_next = EXEC;
         EXEC:                  state_next = SEND;
         SEND:    if (!tx_busy) state_next = WAIT_A;
         default:               state_next = WAIT_A;
      endcase
   end

   assign ready = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);

`ifdef ALU_IF_OPCHECK_EN
   logic bad_op;

   always_ff @(posedge clk) begin
      if (reset) begin
         dato1    <= '0;
         dato2    <= '0;
         op_code  <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         error    <= 1'b0;
         bad_op   <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            WAIT_A: if (rx_done) begin
               dato1 <= rx_data[NB_IN-1:0];
               error <= 1'b0;
            end
            WAIT_B: if (rx_done) dato2 <= rx_data[NB_IN-1:0];
            WAIT_OP: if (rx_done) begin
               // An illegal opcode never reaches the ALU; the last legal one stays applied.
               bad_op <= !is_legal_op(6'(rx_data[NB_CODE-1:0]));
               if (is_legal_op(6'(rx_data[NB_CODE-1:0])))
                  op_code <= rx_data[NB_CODE-1:0];
            end
            EXEC: begin
               tx_data <= bad_op ? NB_DATA'(ERR_BYTE) : NB_DATA'(salida);
               error   <= bad_op;
            end
            SEND: if (!tx_busy) tx_start <= 1'b1;
            default: ;
         endcase
      end
   end
`else
   assign error = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         dato1    <= '0;
         dato2    <= '0;
         op_code  <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            WAIT_A:  if (rx_done) dato1   <= rx_data[NB_IN-1:0];
            WAIT_B:  if (rx_done) dato2   <= rx_data[NB_IN-1:0];
            WAIT_OP: if (rx_done) op_code <= rx_data[NB_CODE-1:0];
            EXEC:    tx_data <= NB_DATA'(salida);
            SEND:    if (!tx_busy) tx_start <= 1'b1;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_alu_rx_interface.sv
// tb/tb_alu_rx_interface.sv - directed vector bench for alu_rx_interface with a behavioural ALU
// Opcode-check vectors run only when ALU_IF_OPCHECK_EN is defined.
module tb_alu_rx_interface;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic [7:0] dato1, dato2, salida, tx_data;
   logic [5:0] op_code;
   logic       tx_start, tx_busy = 1'b0, ready, error;

   int n_vec  = 0;
   int n_fail = 0;

   alu_rx_interface dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .dato1(dato1), .dato2(dato2), .op_code(op_code), .salida(salida),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .ready(ready), .error(error)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (op_code)
         ADD:     salida = dato1 + dato2;
         SUB:     salida = dato1 - dato2;
         AND:     salida = dato1 & dato2;
         OR:      salida = dato1 | dato2;
         XOR:     salida = dato1 ^ dato2;
         SRA:     salida = 8'($signed(dato1) >>> dato2);
         SRL:     salida = dato1 >> dato2;
         NOR:     salida = ~(dato1 | dato2);
         default: salida = 8'h00;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] exp_tx;
      logic [5:0] exp_op;
      logic       exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   // Full packet with tx_busy low: checks capture, EXEC result, single tx_start pulse at k+2.
   task automatic run_vec(input vec_t v);
      send_byte(v.a);
      tick();
      send_byte(v.b);
      send_byte(v.op);
      check("dato1", dato1, v.a);
      check("dato2", dato2, v.b);
      check("op_code", op_code, v.exp_op);
      check("ready_exec", ready, 0);
      check("tx_start_k", tx_start, 0);
      tick();
      check("tx_data", tx_data, v.exp_tx);
      check("tx_start_k1", tx_start, 0);
      check("error", error, v.exp_err);
      tick();
      check("tx_start_k2", tx_start, 1);
      check("ready_back", ready, 1);
      tick();
      check("tx_start_k3", tx_start, 0);
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{8'h05, 8'h03, 8'h20, 8'h08, 6'h20, 1'b0});
      vecs.push_back('{8'h03, 8'h05, 8'h22, 8'hFE, 6'h22, 1'b0});
      vecs.push_back('{8'h80, 8'h02, 8'h03, 8'hE0, 6'h03, 1'b0});
      vecs.push_back('{8'h80, 8'h02, 8'h02, 8'h20, 6'h02, 1'b0});
      vecs.push_back('{8'hF0, 8'h0F, 8'h25, 8'hFF, 6'h25, 1'b0});
      vecs.push_back('{8'hFF, 8'h0F, 8'h26, 8'hF0, 6'h26, 1'b0});

      tick();
      tick();
      reset = 1'b0;
      check("rst_dato1", dato1, 0);
      check("rst_dato2", dato2, 0);
      check("rst_op", op_code, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_ready", ready, 1);
      check("rst_error", error, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Transmitter busy during SEND, with a stray byte that must be ignored.
      tx_busy = 1'b1;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h20);
      tick();
      check("busy_tx_data", tx_data, 8'h33);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) send_byte(8'h55);
         else tick();
         check("busy_no_start", tx_start, 0);
         check("busy_ready", ready, 0);
         check("busy_tx_hold", tx_data, 8'h33);
      end
      tx_busy = 1'b0;
      tick();
      check("busy_start", tx_start, 1);
      check("stray_dato1", dato1, 8'h11);
      tick();
      check("busy_start_end", tx_start, 0);
      run_vec('{8'h0F, 8'hF0, 8'h27, 8'h00, 6'h27, 1'b0});

      // Reset aborts a partial packet.
      send_byte(8'hAA);
      check("partial_dato1", dato1, 8'hAA);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_dato1", dato1, 0);
      check("abort_dato2", dato2, 0);
      check("abort_op", op_code, 0);
      check("abort_tx_data", tx_data, 0);
      check("abort_ready", ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_start", tx_start, 0);
      end
      run_vec('{8'hAA, 8'h0F, 8'h24, 8'h0A, 6'h24, 1'b0});

      // Reset in SEND with tx_busy low: no tx_start.
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h20);
      tick();
      check("sendrst_tx_data", tx_data, 8'h03);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("sendrst_no_start", tx_start, 0);
      check("sendrst_ready", ready, 1);
      tick();
      check("sendrst_no_start2", tx_start, 0);
      run_vec('{8'hAA, 8'h0F, 8'h24, 8'h0A, 6'h24, 1'b0});

`ifdef ALU_IF_OPCHECK_EN
      run_vec('{8'h01, 8'h01, 8'h3F, 8'hFF, 6'h24, 1'b1});
      check("err_held", error, 1);
      send_byte(8'h01);
      check("err_clear", error, 0);
      send_byte(8'h01);
      send_byte(8'h20);
      tick();
      check("add_tx_data", tx_data, 8'h02);
      check("add_error", error, 0);
      tick();
      check("add_start", tx_start, 1);
      tick();
`else
      run_vec('{8'h01, 8'h01, 8'h3F, 8'h00, 6'h3F, 1'b0});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
